// File: rtl/vdc_pkg.sv
// Shared definitions for the Van der Corput phase generator.
package vdc_pkg;

  // base_sel encoding
  localparam logic [1:0] BASE_SEL_2 = 2'b00;
  localparam logic [1:0] BASE_SEL_3 = 2'b01;
  localparam logic [1:0] BASE_SEL_5 = 2'b10;
  localparam logic [1:0] BASE_SEL_7 = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Map a base selector to the numeric base.
  function automatic logic [2:0] base_of(input logic [1:0] sel);
    logic [2:0] b;
    case (sel)
      BASE_SEL_2: b = 3'd2;
      BASE_SEL_3: b = 3'd3;
      BASE_SEL_5: b = 3'd5;
      BASE_SEL_7: b = 3'd7;
      default:    b = 3'd2;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/vdc_digit_step.sv
// One base-b digit extraction: divides the remaining index and the current
// place-value unit by a small constant base.
module vdc_digit_step
  import vdc_pkg::*;
#(
  parameter int K_WIDTH    = 32,
  parameter int UNIT_WIDTH = 25
) (
  input  logic [1:0]            base_sel,
  input  logic [K_WIDTH-1:0]    k_rem,
  input  logic [UNIT_WIDTH-1:0] unit,
  output logic [K_WIDTH-1:0]    k_rem_next,
  output logic [2:0]            digit,
  output logic [UNIT_WIDTH-1:0] unit_next
);

  // Constant-divisor quotients per base; each branch divides by a literal so
  // synthesis builds a fixed-constant divider rather than a generic one.
  always_comb begin
    k_rem_next = k_rem;
    unit_next  = unit;
    case (base_sel)
      BASE_SEL_2: begin
        k_rem_next = k_rem / K_WIDTH'(32'd2);
        unit_next  = unit / UNIT_WIDTH'(32'd2);
      end
      BASE_SEL_3: begin
        k_rem_next = k_rem / K_WIDTH'(32'd3);
        unit_next  = unit / UNIT_WIDTH'(32'd3);
      end
      BASE_SEL_5: begin
        k_rem_next = k_rem / K_WIDTH'(32'd5);
        unit_next  = unit / UNIT_WIDTH'(32'd5);
      end
      BASE_SEL_7: begin
        k_rem_next = k_rem / K_WIDTH'(32'd7);
        unit_next  = unit / UNIT_WIDTH'(32'd7);
      end
      default: begin
        k_rem_next = k_rem;
        unit_next  = unit;
      end
    endcase
  end

  // Remainder recovered from the quotient; it is always below the base so
  // three bits hold it.
  always_comb begin
    digit = 3'(k_rem - k_rem_next * K_WIDTH'(base_of(base_sel)));
  end

endmodule

// File: rtl/vdc_phase_gen.sv
// Sequential Van der Corput phase generator. Produces vdc(k, base) as an
// angle in fixed-point turns, one digit per cycle, with a valid/ready output
// and an optional auto-increment streaming mode.
module vdc_phase_gen
  import vdc_pkg::*;
#(
  parameter int K_WIDTH     = 32,
  parameter int PHASE_WIDTH = 16,
  parameter int GUARD_BITS  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [K_WIDTH-1:0]     k_in,
  input  logic [1:0]             base_sel,
  input  logic                   auto_inc,
  input  logic                   stop,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic [K_WIDTH-1:0]     k_out,
  output logic                   busy
);

  localparam int FRAC_WIDTH = PHASE_WIDTH + GUARD_BITS;
  localparam int UNIT_WIDTH = FRAC_WIDTH + 1;
  localparam logic [UNIT_WIDTH-1:0] UNIT_ONE = {1'b1, {FRAC_WIDTH{1'b0}}};
  localparam logic [K_WIDTH-1:0]    K_ONE    = {{(K_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [1:0]             sel_q, sel_d;
  logic                   auto_q, auto_d;
  logic [K_WIDTH-1:0]     k_cur_q, k_cur_d;
  logic [K_WIDTH-1:0]     k_rem_q, k_rem_d;
  logic [FRAC_WIDTH-1:0]  acc_q, acc_d;
  logic [UNIT_WIDTH-1:0]  unit_q, unit_d;
  logic                   out_valid_q, out_valid_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [K_WIDTH-1:0]     k_out_q, k_out_d;
  logic                   busy_q, busy_d;

  logic [K_WIDTH-1:0]     k_rem_next_s;
  logic [2:0]             digit_s;
  logic [UNIT_WIDTH-1:0]  unit_next_s;
  logic [UNIT_WIDTH+2:0]  addend_s;
  logic                   handshake_s;
  logic                   auto_keep_s;
  logic [K_WIDTH-1:0]     k_inc_s;

  vdc_digit_step #(
    .K_WIDTH    (K_WIDTH),
    .UNIT_WIDTH (UNIT_WIDTH)
  ) u_digit_step (
    .base_sel   (sel_q),
    .k_rem      (k_rem_q),
    .unit       (unit_q),
    .k_rem_next (k_rem_next_s),
    .digit      (digit_s),
    .unit_next  (unit_next_s)
  );

  // Datapath helpers: digit contribution, handshake, stop-adjusted auto flag.
  always_comb begin
    addend_s    = {{UNIT_WIDTH{1'b0}}, digit_s} * {3'b000, unit_next_s};
    handshake_s = (state_q == ST_OUT) && out_valid_q && out_ready;
    auto_keep_s = auto_q && !stop;
    k_inc_s     = k_cur_q + K_ONE;
  end

  // Next-state and register-update logic for the controller.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    auto_d      = auto_q;
    k_cur_d     = k_cur_q;
    k_rem_d     = k_rem_q;
    acc_d       = acc_q;
    unit_d      = unit_q;
    out_valid_d = out_valid_q;
    phase_d     = phase_q;
    k_out_d     = k_out_q;

    // stop in any busy cycle ends streaming after the point in flight
    if (state_q != ST_IDLE) begin
      auto_d = auto_keep_s;
    end else begin
      auto_d = auto_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ITER;
          sel_d   = base_sel;
          auto_d  = auto_inc;
          k_cur_d = k_in;
          k_rem_d = k_in;
          acc_d   = {FRAC_WIDTH{1'b0}};
          unit_d  = UNIT_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (k_rem_q == {K_WIDTH{1'b0}}) begin
          state_d     = ST_OUT;
          out_valid_d = 1'b1;
          phase_d     = acc_q[FRAC_WIDTH-1 -: PHASE_WIDTH];
          k_out_d     = k_cur_q;
        end else begin
          k_rem_d = k_rem_next_s;
          unit_d  = unit_next_s;
          acc_d   = acc_q + addend_s[FRAC_WIDTH-1:0];
        end
      end
      ST_OUT: begin
        if (handshake_s) begin
          out_valid_d = 1'b0;
          if (auto_keep_s) begin
            // stream the next index straight into ITER with no idle gap
            state_d = ST_ITER;
            k_cur_d = k_inc_s;
            k_rem_d = k_inc_s;
            acc_d   = {FRAC_WIDTH{1'b0}};
            unit_d  = UNIT_ONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= 2'b00;
      auto_q      <= 1'b0;
      k_cur_q     <= {K_WIDTH{1'b0}};
      k_rem_q     <= {K_WIDTH{1'b0}};
      acc_q       <= {FRAC_WIDTH{1'b0}};
      unit_q      <= {UNIT_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      phase_q     <= {PHASE_WIDTH{1'b0}};
      k_out_q     <= {K_WIDTH{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      auto_q      <= auto_d;
      k_cur_q     <= k_cur_d;
      k_rem_q     <= k_rem_d;
      acc_q       <= acc_d;
      unit_q      <= unit_d;
      out_valid_q <= out_valid_d;
      phase_q     <= phase_d;
      k_out_q     <= k_out_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign phase     = phase_q;
  assign k_out     = k_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vdc_phase_gen.sv
// Self-checking bench for vdc_phase_gen with a digit-expansion reference model.
module tb_vdc_phase_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] k_in;
  logic [1:0]  base_sel;
  logic        auto_inc;
  logic        stop;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] phase;
  logic [31:0] k_out;
  logic        busy;

  int errors = 0;
  int checks = 0;

  vdc_phase_gen #(
    .K_WIDTH     (32),
    .PHASE_WIDTH (16),
    .GUARD_BITS  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_in      (k_in),
    .base_sel  (base_sel),
    .auto_inc  (auto_inc),
    .stop      (stop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .phase     (phase),
    .k_out     (k_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int tb_base(input logic [1:0] sel);
    case (sel)
      2'd0: return 2;
      2'd1: return 3;
      2'd2: return 5;
      default: return 7;
    endcase
  endfunction

  // vdc(k,b): sum of digit_i * floor(2^24 / b^(i+1)) with the unit floored
  // at each step, then truncated to the top 16 of 24 fraction bits.
  function automatic logic [15:0] ref_phase(input logic [31:0] k, input int b);
    longint unsigned kk, unit, acc, bb;
    kk = k; bb = b; unit = 64'd1 << 24; acc = 64'd0;
    while (kk != 0) begin
      unit = unit / bb;
      acc  = acc + (kk % bb) * unit;
      kk   = kk / bb;
    end
    return 16'((acc >> 8) & 64'hFFFF);
  endfunction

  function automatic int ndig(input logic [31:0] k, input int b);
    longint unsigned kk, bb;
    int n;
    kk = k; bb = b; n = 0;
    while (kk != 0) begin
      kk = kk / bb;
      n++;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid, counting edges; gives up after a fixed budget.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!out_valid && cyc < 200);
  endtask

  // Single point with out_ready high: latency, result, then handshake to IDLE.
  task automatic run_point(input string tag, input logic [1:0] sel,
                           input logic [31:0] k, input logic [15:0] exp_phase);
    int cyc;
    int b;
    b = tb_base(sel);
    start = 1'b1; base_sel = sel; k_in = k; auto_inc = 1'b0;
    tick();
    start = 1'b0;
    k_in = $urandom;              // post-load input changes must be ignored
    base_sel = 2'($urandom);
    wait_valid(cyc);
    check({tag, "_lat"},   64'(cyc),   64'(ndig(k, b) + 1));
    check({tag, "_phase"}, 64'(phase), 64'(exp_phase));
    check({tag, "_kout"},  64'(k_out), 64'(k));
    tick();
    check({tag, "_done"},  64'({out_valid, busy}), 64'd0);
  endtask

  initial begin
    int cyc, pts, seen;
    logic [31:0] exp_k [4];
    logic [15:0] hold_phase;
    logic [31:0] hold_k;
    logic [1:0]  sel;
    logic [31:0] k;

    rst = 1'b1; start = 1'b0; k_in = 32'd0; base_sel = 2'd0;
    auto_inc = 1'b0; stop = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_phase", 64'(phase),     64'd0);
    check("rst_kout",  64'(k_out),     64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    rst = 1'b0;
    tick();

    // Directed points with literal expectations
    run_point("b2k1", 2'd0, 32'd1, 16'h8000);
    run_point("b2k3", 2'd0, 32'd3, 16'hC000);
    run_point("b3k1", 2'd1, 32'd1, 16'h5555);
    run_point("b3k2", 2'd1, 32'd2, 16'hAAAA);
    run_point("b5k1", 2'd2, 32'd1, 16'h3333);
    run_point("b7k1", 2'd3, 32'd1, 16'h2492);
    run_point("b5k0", 2'd2, 32'd0, 16'h0000);
    run_point("b7k0", 2'd3, 32'd0, 16'h0000);

    // Streaming across the index wrap, stopped during the fourth point
    exp_k[0] = 32'hFFFF_FFFE; exp_k[1] = 32'hFFFF_FFFF;
    exp_k[2] = 32'h0000_0000; exp_k[3] = 32'h0000_0001;
    start = 1'b1; base_sel = 2'd0; k_in = 32'hFFFF_FFFE; auto_inc = 1'b1;
    tick();
    start = 1'b0; auto_inc = 1'b0;
    pts = 0; cyc = 0; seen = 0;
    while (pts < 4 && seen < 400) begin
      tick();
      cyc++; seen++;
      if (out_valid) begin
        check("strm_lat",   64'(cyc),   64'(ndig(exp_k[pts], 2) + 1));
        check("strm_kout",  64'(k_out), 64'(exp_k[pts]));
        check("strm_phase", 64'(phase), 64'(ref_phase(exp_k[pts], 2)));
        pts++;
        if (pts == 4) stop = 1'b1;
        cyc = -1;
      end
    end
    check("strm_points", 64'(pts), 64'd4);
    tick();
    stop = 1'b0;
    check("strm_end_valid", 64'(out_valid), 64'd0);
    check("strm_end_busy",  64'(busy),      64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid || busy) seen++;
    end
    check("strm_quiet", 64'(seen), 64'd0);

    // Backpressure: hold in OUT, ignore start, single handshake on release
    out_ready = 1'b0;
    start = 1'b1; base_sel = 2'd1; k_in = 32'd5;
    tick();
    start = 1'b0;
    wait_valid(cyc);
    check("bp_lat",   64'(cyc),   64'(ndig(32'd5, 3) + 1));
    check("bp_phase", 64'(phase), 64'(ref_phase(32'd5, 3)));
    hold_phase = phase;
    hold_k = k_out;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        start = 1'b1; k_in = 32'd7; base_sel = 2'd0;
      end
      tick();
      start = 1'b0;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_phase", 64'(phase),     64'(hold_phase));
      check("bp_hold_kout",  64'(k_out),     64'd5);
      check("bp_hold_kout2", 64'(k_out),     64'(hold_k));
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_busy",  64'(busy),      64'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid || busy) seen++;
    end
    check("bp_single_hs", 64'(seen), 64'd0);

    // Reset during ITER aborts the point
    start = 1'b1; base_sel = 2'd1; k_in = 32'd1000;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy",  64'(busy),      64'd0);
    tick();
    check("mid_rst_valid2", 64'(out_valid), 64'd0);
    check("mid_rst_busy2",  64'(busy),      64'd0);
    rst = 1'b0;
    tick();
    run_point("post_rst", 2'd0, 32'd1, 16'h8000);

    // Randomized points against the reference model
    for (int i = 0; i < 24; i++) begin
      sel = 2'($urandom_range(0, 3));
      if (i % 3 == 0) k = 32'($urandom_range(0, 40));
      else            k = $urandom;
      run_point("rand", sel, k, ref_phase(k, tb_base(sel)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
